// File: rtl/cbuf_pkg.sv
// Shared width helpers and arithmetic for the variable-parallelism circular buffer.
package cbuf_pkg;

  function automatic int unsigned ptr_w(input int unsigned depth);
    if (depth > 32'd1) begin
      return $clog2(depth);
    end else begin
      return 32'd1;
    end
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

  function automatic int unsigned num_w(input int unsigned par);
    return $clog2(par + 32'd1);
  endfunction

  // Requests larger than the lane count are served as a full-width transfer.
  function automatic int unsigned clamp_num(input int unsigned n, input int unsigned max_n);
    if (n > max_n) begin
      return max_n;
    end else begin
      return n;
    end
  endfunction

  // Modular add without a divider; valid because n never exceeds depth.
  function automatic int unsigned ptr_add(input int unsigned ptr, input int unsigned n,
                                          input int unsigned depth);
    int unsigned sum;
    sum = ptr + n;
    if (sum >= depth) begin
      return sum - depth;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/cbuf_ptr.sv
// Wrapping pointer register: advances by step (0..DEPTH) modulo DEPTH when enabled.
module cbuf_ptr
  import cbuf_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned STEP_W = 3,
  localparam int unsigned PTR_W = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [STEP_W-1:0] step,
  output logic [PTR_W-1:0]  ptr
);

  localparam int unsigned SUM_W = PTR_W + 1;

  logic [PTR_W-1:0] r_ptr;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_next;

  // One extra bit holds ptr + step before the single conditional subtract.
  always_comb begin
    w_sum = {1'b0, r_ptr} + SUM_W'(step);
    if (w_sum >= SUM_W'(DEPTH)) begin
      w_next = w_sum - SUM_W'(DEPTH);
    end else begin
      w_next = w_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= {PTR_W{1'b0}};
    end else if (en) begin
      r_ptr <= w_next[PTR_W-1:0];
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/circ_buffer_vp.sv
// Circular buffer pushing 0..PAR_WRITE and popping 0..PAR_READ words per cycle.
// Optional sticky overflow/underflow flags are built when CBUF_ERR_FLAGS_EN is defined.
module circ_buffer_vp
  import cbuf_pkg::*;
#(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PAR_WRITE = 4,
  parameter int unsigned PAR_READ  = 4,
  localparam int unsigned PTR_W = ptr_w(DEPTH),
  localparam int unsigned CNT_W = cnt_w(DEPTH),
  localparam int unsigned WN_W  = num_w(PAR_WRITE),
  localparam int unsigned RN_W  = num_w(PAR_READ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [WN_W-1:0]          wr_num,
  input  logic [PAR_WRITE*SIZE-1:0] din,
  output logic                     wr_ready,
  input  logic                     rd_req,
  input  logic [RN_W-1:0]          rd_num,
  output logic                     rd_valid,
  output logic [PAR_READ*SIZE-1:0] dout,
  output logic [CNT_W-1:0]         count,
  output logic                     empty,
`ifdef CBUF_ERR_FLAGS_EN
  output logic                     full,
  output logic                     ovf_err,
  output logic                     unf_err
`else
  output logic                     full
`endif
);

  logic [SIZE-1:0]  r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] w_wr_n;
  logic [CNT_W-1:0] w_rd_n;
  logic [CNT_W-1:0] w_free;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic [PTR_W-1:0] w_wr_addr [PAR_WRITE];
  logic [PTR_W-1:0] w_rd_addr [PAR_READ];

  // Handshakes look only at registered occupancy, never at the request strobes.
  always_comb begin
    w_wr_n   = CNT_W'(clamp_num(32'(wr_num), PAR_WRITE));
    w_rd_n   = CNT_W'(clamp_num(32'(rd_num), PAR_READ));
    w_free   = CNT_W'(DEPTH) - r_count;
    wr_ready = (w_free >= w_wr_n);
    rd_valid = (r_count >= w_rd_n);
    w_wr_acc = wr_valid & wr_ready;
    w_rd_acc = rd_req & rd_valid;
    w_count_next = r_count + (w_wr_acc ? w_wr_n : {CNT_W{1'b0}})
                           - (w_rd_acc ? w_rd_n : {CNT_W{1'b0}});
  end

  always_comb begin
    for (int unsigned i = 0; i < PAR_WRITE; i++) begin
      w_wr_addr[i] = PTR_W'(ptr_add(32'(w_wr_ptr), i, DEPTH));
    end
    for (int unsigned j = 0; j < PAR_READ; j++) begin
      w_rd_addr[j] = PTR_W'(ptr_add(32'(w_rd_ptr), j, DEPTH));
    end
  end

  cbuf_ptr #(.DEPTH(DEPTH), .STEP_W(WN_W)) u_wr_ptr (
    .clk  (clk),
    .rst  (rst),
    .en   (w_wr_acc),
    .step (WN_W'(w_wr_n)),
    .ptr  (w_wr_ptr)
  );

  cbuf_ptr #(.DEPTH(DEPTH), .STEP_W(RN_W)) u_rd_ptr (
    .clk  (clk),
    .rst  (rst),
    .en   (w_rd_acc),
    .step (RN_W'(w_rd_n)),
    .ptr  (w_rd_ptr)
  );

  // Storage has no reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < PAR_WRITE; i++) begin
      if (!rst && w_wr_acc && (i < 32'(w_wr_n))) begin
        r_mem[w_wr_addr[i]] <= din[i*SIZE +: SIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_count <= w_count_next;
    end
  end

  // Lanes beyond the request or beyond occupancy read as zero, so stale slots never leak.
  always_comb begin
    dout = {(PAR_READ*SIZE){1'b0}};
    for (int unsigned j = 0; j < PAR_READ; j++) begin
      if ((j < 32'(w_rd_n)) && (j < 32'(r_count))) begin
        dout[j*SIZE +: SIZE] = r_mem[w_rd_addr[j]];
      end else begin
        dout[j*SIZE +: SIZE] = {SIZE{1'b0}};
      end
    end
  end

  assign count = r_count;
  assign empty = (r_count == {CNT_W{1'b0}});
  assign full  = (r_count == CNT_W'(DEPTH));

`ifdef CBUF_ERR_FLAGS_EN
  logic r_ovf_err;
  logic r_unf_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      r_ovf_err <= r_ovf_err | (wr_valid & ~wr_ready);
      r_unf_err <= r_unf_err | (rd_req & ~rd_valid);
    end
  end

  assign ovf_err = r_ovf_err;
  assign unf_err = r_unf_err;
`endif

endmodule

// File: tb/tb_circ_buffer_vp.sv
// Bench for circ_buffer_vp: directed vector table, corner sequences, and random traffic
// checked against a queue-based occupancy model.
module tb_circ_buffer_vp;

  localparam int SIZE  = 8;
  localparam int DEPTH = 16;
  localparam int PW    = 4;
  localparam int PR    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [2:0]  wr_num;
  logic [31:0] din;
  logic        wr_ready;
  logic        rd_req;
  logic [2:0]  rd_num;
  logic        rd_valid;
  logic [31:0] dout;
  logic [4:0]  count;
  logic        empty;
  logic        full;
`ifdef CBUF_ERR_FLAGS_EN
  logic        ovf_err;
  logic        unf_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  byte unsigned mdl_q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  always #5 clk = ~clk;

  circ_buffer_vp #(.SIZE(SIZE), .DEPTH(DEPTH), .PAR_WRITE(PW), .PAR_READ(PR)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_num   (wr_num),
    .din      (din),
    .wr_ready (wr_ready),
    .rd_req   (rd_req),
    .rd_num   (rd_num),
    .rd_valid (rd_valid),
    .dout     (dout),
    .count    (count),
    .empty    (empty),
`ifdef CBUF_ERR_FLAGS_EN
    .full     (full),
    .ovf_err  (ovf_err),
    .unf_err  (unf_err)
`else
    .full     (full)
`endif
  );

  typedef struct {
    logic        wv;
    logic [2:0]  wn;
    logic [31:0] d;
    logic        rq;
    logic [2:0]  rn;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_dout;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic wv, input logic [2:0] wn, input logic [31:0] d,
                              input logic rq, input logic [2:0] rn, input logic e_rdy,
                              input logic e_vld, input logic [31:0] e_dout, input int e_cnt);
    tbl.push_back('{wv, wn, d, rq, rn, e_rdy, e_vld, e_dout, e_cnt});
  endfunction

  // One clock of traffic checked against the queue model; model updates at the edge.
  task automatic cyc(input logic r, input logic wv, input logic [2:0] wn, input logic [31:0] d,
                     input logic rq, input logic [2:0] rn);
    int wc, rc, occ;
    logic er, ev;
    logic [31:0] ed;
    rst = r; wr_valid = wv; wr_num = wn; din = d; rd_req = rq; rd_num = rn;
    #1;
    wc  = (int'(wn) > PW) ? PW : int'(wn);
    rc  = (int'(rn) > PR) ? PR : int'(rn);
    occ = mdl_q.size();
    er  = ((DEPTH - occ) >= wc);
    ev  = (occ >= rc);
    ed  = 32'h0;
    for (int i = 0; i < rc; i++) begin
      if (i < occ) ed[i*8 +: 8] = mdl_q[i];
    end
    chk("wr_ready", 32'(wr_ready), 32'(er));
    chk("rd_valid", 32'(rd_valid), 32'(ev));
    if (ev) chk("dout", dout, ed);
    @(posedge clk);
    #1;
    if (r) begin
      mdl_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (wv && !er) m_ovf = 1'b1;
      if (rq && !ev) m_unf = 1'b1;
      if (rq && ev) repeat (rc) void'(mdl_q.pop_front());
      if (wv && er) for (int i = 0; i < wc; i++) mdl_q.push_back(d[i*8 +: 8]);
    end
    chk("count", 32'(count), 32'(mdl_q.size()));
    chk("empty", 32'(empty), 32'(mdl_q.size() == 0));
    chk("full",  32'(full),  32'(mdl_q.size() == DEPTH));
`ifdef CBUF_ERR_FLAGS_EN
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    chk("unf_err", 32'(unf_err), 32'(m_unf));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_num = 3'd0; din = 32'h0; rd_req = 1'b0; rd_num = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);

    //   wv    wn    din            rq    rn    rdy   vld   dout           cnt
    add(1'b0, 3'd4, 32'h00000000, 1'b0, 3'd1, 1'b1, 1'b0, 32'h00000000, 0);
    add(1'b1, 3'd4, 32'h13121110, 1'b0, 3'd0, 1'b1, 1'b1, 32'h00000000, 4);
    add(1'b1, 3'd4, 32'h13121110, 1'b0, 3'd0, 1'b1, 1'b1, 32'h00000000, 8);
    add(1'b1, 3'd4, 32'h13121110, 1'b0, 3'd0, 1'b1, 1'b1, 32'h00000000, 12);
    add(1'b1, 3'd4, 32'h13121110, 1'b0, 3'd0, 1'b1, 1'b1, 32'h00000000, 16);
    add(1'b1, 3'd1, 32'h000000FF, 1'b0, 3'd0, 1'b0, 1'b1, 32'h00000000, 16);
    add(1'b0, 3'd0, 32'h00000000, 1'b1, 3'd4, 1'b1, 1'b1, 32'h13121110, 12);
    add(1'b0, 3'd0, 32'h00000000, 1'b1, 3'd4, 1'b1, 1'b1, 32'h13121110, 8);
    add(1'b0, 3'd0, 32'h00000000, 1'b1, 3'd4, 1'b1, 1'b1, 32'h13121110, 4);
    add(1'b0, 3'd0, 32'h00000000, 1'b1, 3'd4, 1'b1, 1'b1, 32'h13121110, 0);
    add(1'b1, 3'd3, 32'hEEA2A1A0, 1'b0, 3'd3, 1'b1, 1'b0, 32'h00000000, 3);
    add(1'b0, 3'd0, 32'h00000000, 1'b1, 3'd3, 1'b1, 1'b1, 32'h00A2A1A0, 0);
    add(1'b1, 3'd7, 32'h44332211, 1'b0, 3'd0, 1'b1, 1'b1, 32'h00000000, 4);
    add(1'b0, 3'd0, 32'h00000000, 1'b1, 3'd5, 1'b1, 1'b1, 32'h44332211, 0);
    add(1'b1, 3'd4, 32'h03020100, 1'b0, 3'd0, 1'b1, 1'b1, 32'h00000000, 4);
    add(1'b1, 3'd4, 32'h07060504, 1'b0, 3'd0, 1'b1, 1'b1, 32'h00000000, 8);
    add(1'b1, 3'd4, 32'h0B0A0908, 1'b1, 3'd2, 1'b1, 1'b1, 32'h00000100, 10);
    add(1'b0, 3'd0, 32'h00000000, 1'b1, 3'd4, 1'b1, 1'b1, 32'h05040302, 6);
    add(1'b0, 3'd0, 32'h00000000, 1'b1, 3'd4, 1'b1, 1'b1, 32'h09080706, 2);
    add(1'b0, 3'd0, 32'h00000000, 1'b1, 3'd4, 1'b1, 1'b0, 32'h00000000, 2);
    add(1'b0, 3'd0, 32'h00000000, 1'b1, 3'd2, 1'b1, 1'b1, 32'h00000B0A, 0);
    add(1'b1, 3'd2, 32'h0000BBAA, 1'b1, 3'd1, 1'b1, 1'b0, 32'h00000000, 2);
    add(1'b0, 3'd0, 32'h00000000, 1'b1, 3'd2, 1'b1, 1'b1, 32'h0000BBAA, 0);
    add(1'b1, 3'd0, 32'hFFFFFFFF, 1'b0, 3'd0, 1'b1, 1'b1, 32'h00000000, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      rst = 1'b0; wr_valid = tbl[k].wv; wr_num = tbl[k].wn; din = tbl[k].d;
      rd_req = tbl[k].rq; rd_num = tbl[k].rn;
      #1;
      chk($sformatf("vec%0d_wr_ready", k), 32'(wr_ready), 32'(tbl[k].e_rdy));
      chk($sformatf("vec%0d_rd_valid", k), 32'(rd_valid), 32'(tbl[k].e_vld));
      if (tbl[k].e_vld) chk($sformatf("vec%0d_dout", k), dout, tbl[k].e_dout);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", k), 32'(count), 32'(tbl[k].e_cnt));
      chk($sformatf("vec%0d_empty", k), 32'(empty), 32'(tbl[k].e_cnt == 0));
      chk($sformatf("vec%0d_full", k),  32'(full),  32'(tbl[k].e_cnt == DEPTH));
    end

    // Wrap: move both pointers to 14, then a 4-word transfer straddles the end.
    cyc(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
    repeat (3) cyc(1'b0, 1'b1, 3'd4, $urandom, 1'b0, 3'd0);
    repeat (3) cyc(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd4);
    cyc(1'b0, 1'b1, 3'd2, $urandom, 1'b0, 3'd0);
    cyc(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2);
    cyc(1'b0, 1'b1, 3'd4, 32'h53525150, 1'b0, 3'd0);
    chk("wrap_slot14", 32'(dut.r_mem[14]), 32'h50);
    chk("wrap_slot15", 32'(dut.r_mem[15]), 32'h51);
    chk("wrap_slot0",  32'(dut.r_mem[0]),  32'h52);
    chk("wrap_slot1",  32'(dut.r_mem[1]),  32'h53);
    cyc(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd4);
    chk("wrap_wr_ptr", 32'(dut.w_wr_ptr), 32'd2);
    chk("wrap_rd_ptr", 32'(dut.w_rd_ptr), 32'd2);

    // Reset mid-stream with a transfer in the same cycle.
    repeat (2) cyc(1'b0, 1'b1, 3'd4, $urandom, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 3'd1, $urandom, 1'b0, 3'd0);
    chk("pre_rst_count", 32'(count), 32'd9);
    cyc(1'b1, 1'b1, 3'd4, $urandom, 1'b1, 3'd2);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);
    cyc(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd1);
    repeat (3) cyc(1'b0, 1'b1, 3'd2, $urandom, 1'b0, 3'd0);
    repeat (6) cyc(1'b0, 1'b1, 3'd4, $urandom, 1'b0, 3'd0);
    cyc(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);

    // Random traffic, write-heavy then read-heavy, with rare resets.
    for (int n = 0; n < 600; n++) begin
      logic wv, rq;
      if (n < 300) begin
        wv = ($urandom_range(0, 3) != 0);
        rq = ($urandom_range(0, 2) == 0);
      end else begin
        wv = ($urandom_range(0, 2) == 0);
        rq = ($urandom_range(0, 3) != 0);
      end
      cyc(($urandom_range(0, 149) == 0), wv, 3'($urandom_range(0, 7)), $urandom,
          rq, 3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
